// File: rtl/bnn_pkg.sv
// Shared types and constants for the streaming XNOR-popcount unit.
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} bnn_state_e;

    localparam logic [1:0] BNN_MODE_POP = 2'd0;
    localparam logic [1:0] BNN_MODE_BIP = 2'd1;
    localparam logic [1:0] BNN_MODE_THR = 2'd2;

    function automatic logic [3:0] byte_popcnt(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(b[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bnn_word_popcnt.sv
// Masked XNOR of one activation/weight word pair, reduced to per-byte popcounts.
module bnn_word_popcnt
    import bnn_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0]             act,
    input  logic [WORD_W-1:0]             wgt,
    // Number of low-order bits that take part (1..WORD_W).
    input  logic [$clog2(WORD_W+1)-1:0]   nbits,
    output logic [WORD_W/8-1:0][3:0]      byte_cnt
);

    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] match;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WORD_W; i++) begin
            mask[i] = (32'(i) < 32'(nbits));
        end
    end

    assign match = ~(act ^ wgt) & mask;

    always_comb begin
        byte_cnt = '0;
        for (int b = 0; b < WORD_W / 8; b++) begin
            byte_cnt[b] = byte_popcnt(match[b*8 +: 8]);
        end
    end

endmodule

// File: rtl/bnn_stream_unit.sv
// Streaming XNOR-popcount over multi-word binary vectors with popcount,
// bipolar and threshold result modes behind a valid/ready command handshake.
module bnn_stream_unit
    import bnn_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned LEN_W     = $clog2(WORD_W * MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cfg_we,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [1:0]        cfg_mode,
    input  logic [31:0]       cfg_thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_act,
    input  logic [WORD_W-1:0] in_wgt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              busy
);

    localparam int unsigned NB      = WORD_W / 8;
    localparam int unsigned CNT_W   = $clog2(WORD_W + 1);
    localparam int unsigned MAX_LEN = WORD_W * MAX_WORDS;

    bnn_state_e state_q, state_d;

    logic [LEN_W-1:0]      len_q;
    logic [1:0]            mode_q;
    logic [1:0]            mode_lat_q;
    logic [31:0]           thresh_q;
    logic [LEN_W-1:0]      acc_q;
    logic [LEN_W-1:0]      wcnt_q;
    logic                  s1_valid_q;
    logic                  s2_valid_q;
    logic [NB-1:0][3:0]    s1_cnt_q;
    logic [CNT_W-1:0]      s2_sum_q;
    logic [31:0]           out_result_q;

    logic [LEN_W-1:0]      nwords;
    logic [LEN_W-1:0]      rem;
    logic                  last_word;
    logic [CNT_W-1:0]      nbits;
    logic [NB-1:0][3:0]    byte_cnt;
    logic [CNT_W-1:0]      word_sum;
    logic                  accept;
    logic                  len_ok;
    logic signed [31:0]    d;
    logic [31:0]           result;

    assign nwords    = LEN_W'((32'(len_q) + WORD_W - 1) / WORD_W);
    assign rem       = LEN_W'(32'(len_q) % WORD_W);
    assign last_word = (wcnt_q == nwords - LEN_W'(1));
    assign nbits     = (last_word && rem != '0) ? CNT_W'(rem) : CNT_W'(WORD_W);

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && in_ready && !flush;
    assign len_ok    = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);

    assign out_valid  = (state_q == RESULT);
    assign out_result = out_result_q;
    assign busy       = (state_q != IDLE);

    bnn_word_popcnt #(
        .WORD_W (WORD_W)
    ) u_word_popcnt (
        .act      (in_act),
        .wgt      (in_wgt),
        .nbits    (nbits),
        .byte_cnt (byte_cnt)
    );

    always_comb begin
        word_sum = '0;
        for (int b = 0; b < NB; b++) begin
            word_sum = word_sum + CNT_W'(s1_cnt_q[b]);
        end
    end

    always_comb begin
        d = (32'(acc_q) << 1) - 32'(len_q);
        case (mode_lat_q)
            BNN_MODE_BIP: result = d;
            BNN_MODE_THR: result = {31'b0, (d >= $signed(thresh_q))};
            default:      result = 32'(acc_q);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = last_word ? DRAIN : ACCUM;
            end
            ACCUM: begin
                if (accept && last_word) state_d = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) state_d = RESULT;
            end
            RESULT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= LEN_W'(WORD_W);
            mode_q       <= BNN_MODE_POP;
            thresh_q     <= '0;
            mode_lat_q   <= BNN_MODE_POP;
            acc_q        <= '0;
            wcnt_q       <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_cnt_q     <= '0;
            s2_sum_q     <= '0;
            out_result_q <= '0;
        end else begin
            if (cfg_we && state_q == IDLE) begin
                if (len_ok) len_q <= cfg_len;
                mode_q   <= cfg_mode;
                thresh_q <= cfg_thresh;
            end
            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
                acc_q      <= '0;
                wcnt_q     <= '0;
            end else begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_cnt_q <= byte_cnt;
                    wcnt_q   <= wcnt_q + LEN_W'(1);
                    if (state_q == IDLE) mode_lat_q <= mode_q;
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_sum_q <= word_sum;
                if (s2_valid_q) acc_q <= acc_q + LEN_W'(s2_sum_q);
                if (state_q == DRAIN && state_d == RESULT) out_result_q <= result;
                // Pipeline is already empty in RESULT, so this clear never drops a word.
                if (state_q == RESULT && out_ready) begin
                    acc_q  <= '0;
                    wcnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_stream_unit.sv
// Scoreboard bench for bnn_stream_unit: directed corner cases plus randomized vectors
// checked against a bit-level reference model.
module tb_bnn_stream_unit;

    localparam int W  = 32;
    localparam int MW = 16;
    localparam int LW = $clog2(W * MW + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          cfg_we;
    logic [LW-1:0] cfg_len;
    logic [1:0]    cfg_mode;
    logic [31:0]   cfg_thresh;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_act;
    logic [W-1:0]  in_wgt;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic          busy;

    always #5 clk = ~clk;

    bnn_stream_unit #(
        .WORD_W    (W),
        .MAX_WORDS (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .cfg_we     (cfg_we),
        .cfg_len    (cfg_len),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_wgt     (in_wgt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    int cyc      = 0;
    int last_acc = 0;

    int m_len    = W;
    int m_mode   = 0;
    int m_thresh = 0;

    bit hold_rdy = 1'b0;
    bit rand_rdy = 1'b0;

    logic [W-1:0] va[MW];
    logic [W-1:0] vw[MW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Reference: walk the vector bit by bit, counting positions where activation equals weight.
    function automatic logic [31:0] model();
        int cnt = 0;
        int d;
        for (int i = 0; i < m_len; i++) begin
            if (va[i / W][i % W] == vw[i / W][i % W]) cnt++;
        end
        d = 2 * cnt - m_len;
        case (m_mode)
            1:       return d;
            2:       return (d >= m_thresh) ? 32'd1 : 32'd0;
            default: return cnt;
        endcase
    endfunction

    // Monitor: compare every cycle a result is presented, pop on handshake.
    initial begin : monitor
        bit prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov = 1'b0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out: got result %0h, required no output", out_result);
                end else begin
                    check("out_result", out_result, exp_q[0]);
                    check("in_ready_in_result", in_ready, 1'b0);
                    if (!prev_ov) begin
                        compared++;
                        if (cyc - last_acc != 3) begin
                            mismatched++;
                            $display("FAIL latency: got %0d edges, required 3", cyc - last_acc);
                        end
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin : ready_driver
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", compared);
        $fatal(1);
    end

    task automatic cfg(input int len, input int mode, input int thr, input bit applies);
        cfg_we     = 1'b1;
        cfg_len    = LW'(len);
        cfg_mode   = 2'(mode);
        cfg_thresh = thr;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (applies) begin
            if (len != 0 && len <= W * MW) m_len = len;
            m_mode   = mode;
            m_thresh = thr;
        end
    endtask

    task automatic send_vec(input bit gaps);
        int n = (m_len + W - 1) / W;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            check("in_ready_accept", in_ready, 1'b1);
            in_valid = 1'b1;
            in_act   = va[i];
            in_wgt   = vw[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        last_acc = cyc;
        exp_q.push_back(model());
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d results pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check({name, "_busy"}, busy, 1'b0);
    endtask

    initial begin : stimulus
        reset = 1'b1; flush = 1'b0; cfg_we = 1'b0; cfg_len = '0; cfg_mode = '0;
        cfg_thresh = '0; in_valid = 1'b0; in_act = '0; in_wgt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted mid-ACCUM with a nonzero partial sum.
        cfg(128, 0, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_act = 32'h1234_5678; in_wgt = 32'h1234_5678;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_len = W; m_mode = 0; m_thresh = 0;
        @(posedge clk);
        #1;
        va[0] = '0; vw[0] = '0;
        send_vec(1'b0);
        drain("rst_default");

        // Single word, popcount mode.
        cfg(32, 0, 0, 1'b1);
        va[0] = 32'hFFFF_0000; vw[0] = 32'h0000_FFFF;
        send_vec(1'b0);
        drain("single_zero");
        vw[0] = 32'hFFFF_0000;
        send_vec(1'b0);
        drain("single_full");

        // Two words with an 8-bit tail, bipolar mode.
        cfg(40, 1, 0, 1'b1);
        va[0] = 32'hA5A5_5A5A; vw[0] = 32'hA5A5_5A5A; va[1] = 32'h0000_0077; vw[1] = 32'h0000_0077;
        send_vec(1'b0);
        drain("bip_match");
        va[1] = 32'h0000_00FF; vw[1] = 32'h0000_0000;
        send_vec(1'b0);
        drain("bip_tail");
        va[1] = 32'hFFFF_FF00; vw[1] = 32'h0000_0000;
        send_vec(1'b0);
        drain("bip_masked_upper");

        // Threshold mode around d = 0.
        cfg(64, 2, 0, 1'b1);
        va[0] = 32'hC3C3_0F0F; vw[0] = 32'hC3C3_0F0F; va[1] = 32'h1357_9BDF; vw[1] = ~32'h1357_9BDF;
        send_vec(1'b0);
        drain("thr_acc32");
        va[0] = 32'hC3C3_0F0E;
        send_vec(1'b0);
        drain("thr_acc31");
        cfg(64, 2, -2, 1'b1);
        send_vec(1'b0);
        drain("thr_neg2");

        // Illegal lengths leave len alone but still write mode.
        cfg(0, 0, 0, 1'b1);
        send_vec(1'b0);
        drain("len_zero_ignored");
        cfg(W * MW + 1, 1, 0, 1'b1);
        send_vec(1'b0);
        drain("len_big_ignored");

        // Output back-pressure and config writes during RESULT.
        hold_rdy = 1'b1;
        send_vec(1'b0);
        begin
            int t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            if (k == 2) cfg(256, 0, 5, 1'b0);
            else begin
                @(posedge clk);
                #1;
            end
        end
        hold_rdy = 1'b0;
        drain("hold");
        va[0] = 32'h0F0F_0F0F; vw[0] = 32'h0F0F_0FFF;
        send_vec(1'b0);
        drain("cfg_in_result_ignored");

        // Flush on the second word of a four-word vector.
        cfg(128, 0, 0, 1'b1);
        in_valid = 1'b1; in_act = 32'hFFFF_FFFF; in_wgt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_out", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            va[i] = $urandom; vw[i] = $urandom;
        end
        send_vec(1'b0);
        drain("after_flush");

        // Randomized vectors with input gaps and output back-pressure.
        rand_rdy = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int len;
            if (it == 0) len = 1;
            else if (it == 1) len = W * MW;
            else len = $urandom_range(1, W * MW);
            cfg(len, $urandom_range(0, 3), int'($urandom_range(0, 2 * len)) - len, 1'b1);
            for (int i = 0; i < MW; i++) begin
                va[i] = $urandom;
                vw[i] = ($urandom_range(0, 1) != 0) ? (va[i] ^ (32'h1 << $urandom_range(0, 31)))
                                                    : 32'($urandom);
            end
            send_vec(1'b1);
            drain("random");
        end
        rand_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bnn_stream_unit.md
# bnn_stream_unit

Parametrised successor to the fixed 32-bit, single-word BNN path. It accepts a binary activation/weight vector as a stream of WORD_W-bit word pairs, computes the XNOR-popcount over a configurable vector length, and returns a raw count, a bipolar dot product or a thresholded sign bit. It sits beside the ALU in the Execute stage and is driven by a small command/response handshake, so multi-word vectors no longer stall the pipeline per word.

## Interface
- WORD_W, 32: bits per input word; multiple of 8, at most 32.
- MAX_WORDS, 16: maximum words per vector; at least 1.
- LEN_W, $clog2(WORD_W*MAX_WORDS+1): width of the length and accumulator fields.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the current vector; configuration is kept.
- cfg_we  in  1  configuration write strobe.
- cfg_len  in  LEN_W  vector length in bits.
- cfg_mode  in  2  result mode: 0 popcount, 1 bipolar, 2 threshold, 3 reserved.
- cfg_thresh  in  32  signed threshold used by mode 2.
- in_valid  in  1  an input word pair is presented.
- in_ready  out  1  the unit can accept a word this cycle.
- in_act, in_wgt  in  WORD_W each  activation and weight words.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_result  out  32  the result.
- busy  out  1  high in any state other than IDLE.

## Operation
- Config registers: len, mode and thresh.
  - Reset values are len=WORD_W, mode=0, thresh=0.
  - A cfg_we write is applied only in IDLE. Writes in any other state are ignored.
  - A write with cfg_len=0 or cfg_len>WORD_W*MAX_WORDS leaves len unchanged; mode and thresh are still written.
- Words per vector: nwords = ceil(len/WORD_W). Let r = len mod WORD_W.
  - The last word uses mask bits [r-1:0], or the full word when r=0.
  - Masked bits contribute 0.
- Per word: p = popcount(~(in_act ^ in_wgt) & mask). The accumulator acc (LEN_W bits) sums p over all words.
- States:
  - IDLE: in_ready=1. The first accepted word latches mode and moves to ACCUM, or to DRAIN when nwords=1.
  - ACCUM: in_ready=1. A word is accepted when in_valid && in_ready. Word counter wcnt increments on each accept. The accept with wcnt==nwords-1 moves to DRAIN.
  - DRAIN: in_ready=0. Waits for the 2-stage pipeline to empty, then computes the result and moves to RESULT.
  - RESULT: out_valid=1 with out_result held stable. out_valid && out_ready returns to IDLE and clears acc and wcnt.
- Result, where d = 2*acc - len is signed:
  - mode 0 and 3: zero-extended acc.
  - mode 1: d sign-extended to 32 bits.
  - mode 2: {31'b0, (d >= $signed(cfg_thresh))}.
- flush:
  - Has priority over every other event.
  - Clears the pipeline valids, acc and wcnt, drops out_valid and goes to IDLE.
  - A word presented in the same cycle is not accepted.
- Reset values: out_valid=0, out_result=0, busy=0, in_ready=1 (IDLE), acc=0, wcnt=0, pipeline valids=0. Reset asserted mid-vector behaves identically.

## Timing
- Pipeline:
  - S1 registers the per-byte popcounts of the masked XNOR on the edge that accepts the word.
  - S2 adds them into acc on the following edge.
  - The result register loads on the edge after the S2 write of the last word.
- Latency: out_valid rises on the 3rd rising edge after the edge that accepts the last word.
- Throughput: one word per cycle while in_valid stays high. No bubbles between words of a vector.
- Back-to-back vectors: the next vector's first word is accepted no earlier than the cycle after the out handshake.
- out_valid stays high until out_ready is seen. out_result is stable throughout.
- in_ready depends only on state, never combinationally on in_valid.

## Structure
- Shared package bnn_pkg holds:
  - the state enum {IDLE, ACCUM, DRAIN, RESULT};
  - mode constants BNN_MODE_POP=0, BNN_MODE_BIP=1, BNN_MODE_THR=2.
- One sub-module, bnn_word_popcnt: mask generation, XNOR and per-byte popcount, producing the S1 combinational output. Parametrised by WORD_W.

## Test plan
- Reset defaults: assert reset mid-ACCUM with acc nonzero -> out_valid=0, busy=0, in_ready=1; the next vector with default len=32 and in_act=in_wgt=0 gives out_result=32.
- Single word, mode 0, len=32: in_act=32'hFFFF0000, in_wgt=32'h0000FFFF -> out_result=0 three edges after the accept; with in_wgt=32'hFFFF0000 -> 32.
- Multi-word with masked tail, mode 1, len=40 (2 words): all bits matching -> out_result=40. With word 1 = 0x000000FF vs 0x00000000 -> bipolar d = 2*32-40 = 24; only 8 bits of word 1 are counted.
- Threshold mode 2, len=64, thresh=0: acc=32 -> out_result=1; acc=31 -> out_result=0; thresh=-2 with acc=31 -> 1.
- Handshake: hold out_ready=0 for 5 cycles -> out_valid and out_result stay stable and in_ready=0; cfg_we during RESULT is ignored (len unchanged).
- Flush: flush on the same cycle as the second of 4 words -> that word is not accepted and state is IDLE. A fresh vector afterwards produces a correct result unaffected by the aborted partial sum.
